rf_read_port_arbiter: RTL and testbench
=======================================

// Module: rf_read_port_arbiter
// PURPOSE
//  Round-robin arbiter that shares one register-file read port among NUM_REQ requesters.
//  Drives the read address and the selector of the shared N:1 mux, and returns read data with a per-requester valid pulse.
//  Sits between the register unit and its clients (decode, debug, CSR/trace readers).
// PARAMETERS
//  NUM_REQ   4   number of requesters (>=1)
//  ADDR_W    5   register address width
//  DATA_W    32  read data width
//  MAX_HOLD  4   max consecutive grant cycles to one owner while another requester waits (>=1)
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  reset, asynchronous, active-high
//  req        in   NUM_REQ            per-requester read request
//  req_addr   in   [NUM_REQ][ADDR_W]  packed 2-D, per-requester register address
//  rf_addr    out  ADDR_W             address to register file
//  rf_rdata   in   DATA_W             combinational read data from register file
//  sel        out  $clog2(NUM_REQ)+1  index of current owner, to shared mux selector
//  gnt        out  NUM_REQ            one-hot grant, registered
//  rsp_valid  out  NUM_REQ            one-hot, 1-cycle pulse: read for that requester completed
//  rsp_data   out  DATA_W             captured read data, valid with rsp_valid
//  busy       out  1                  state == OWN
// BEHAVIOUR
//  Reset (async, any cycle, mid-transfer included):
//   - state=IDLE; gnt=0, sel=0, rsp_valid=0, rsp_data=0; hold_cnt=0.
//   - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
//  Transfer: occurs in any cycle with req[i] & gnt[i].
//   - rf_addr = req_addr[sel] while in OWN; 0 in IDLE.
//   - At the edge ending a transfer cycle: rsp_data <= rf_rdata and rsp_valid[i] <= 1.
//   - rsp_valid is 0 in every other cycle. rsp_data holds between transfers.
//  Latency: req rises in cycle 0 (IDLE) -> gnt in cycle 1 -> rsp_valid/rsp_data in cycle 2.
//  States: IDLE, OWN.
//   IDLE: req==0 stays IDLE. Otherwise -> OWN; winner = first set req after rr_ptr (circular); hold_cnt=0.
//   OWN, owner req high:
//    - hold_cnt<MAX_HOLD-1, or no other req -> keep owner; hold_cnt++ (saturates at MAX_HOLD-1).
//    - Else -> rotate: rr_ptr<=owner; new winner picked after owner; hold_cnt=0.
//   OWN, owner req low: rr_ptr<=owner. If other req set -> pick next winner (hold_cnt=0); else -> IDLE, gnt=0.
//  Decisions use req as sampled at the edge; gnt, sel and rf_addr never change mid-cycle.
//  Requester drops req after its last wanted gnt cycle. Arbitration already decided on req high, so gnt stays
//   one more cycle with no transfer (bubble) and no rsp_valid. This is required behaviour.
//  req_addr is sampled per transfer cycle; it may change between back-to-back transfers of the same owner.
//  NUM_REQ=1: round-robin degenerates; owner 0 keeps gnt while req is high; hold never rotates.
//  gnt is always one-hot or zero; sel == index of set gnt bit, 0 when gnt==0.
// STRUCTURE
//  Package rf_arb_pkg:
//   - typedef enum {IDLE, OWN} arb_state_t.
//   - function sel_w(n) = $clog2(n)+1, matching the shared mux selector width.
//   - default constants NUM_REQ/ADDR_W/DATA_W.
//  Sub-module rr_priority_pick (combinational):
//   - in: req, ptr; out: found, idx, one-hot.
//   - rotate req right by ptr+1, priority-encode lowest set bit, rotate index back.
//  Top: state/owner/hold_cnt/rr_ptr registers, address mux, response capture register.
// TESTING
//  1 Reset: rst=1 mid-transfer with req=4'b1111 -> same cycle gnt=0, rsp_valid=0, busy=0;
//    after release first grant goes to req0.
//  2 Single read: req=4'b0100, req_addr[2]=5'd7, rf_rdata=mem[7]=32'hDEAD_BEEF for 2 cycles then drop ->
//    gnt=4'b0100 in c1 and c2, rsp_valid=4'b0100 with rsp_data=32'hDEAD_BEEF in c2 and c3,
//    bubble cycle with no rsp, IDLE by c4.
//  3 Round robin: req=4'b1111 held, MAX_HOLD=1 -> gnt sequence 0001,0010,0100,1000,0001, one grant per cycle.
//  4 Hold limit: req=4'b0011 held, MAX_HOLD=4 -> gnt 0001 for 4 cycles, then 0010 for 4 cycles, repeating.
//    req0 alone held -> gnt=0001 indefinitely.
//  5 Owner drop with waiter: owner 1 drops req while req3 high, hold_cnt=1 -> next cycle gnt=1000, hold_cnt=0.
//  6 Address change: owner 0 holds req, req_addr[0]=1,2,3 on successive cycles ->
//    rf_addr follows, rsp_data = mem[1],mem[2],mem[3] one cycle later.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file read port arbiter.
package rf_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_HOLD = 4;

    // Width of the shared mux selector; one spare bit keeps NUM_REQ=1 legal.
    function automatic int sel_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Circular priority pick: first set request strictly after ptr, wrapping around.
module rr_priority_pick
    import rf_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]          req,
    input  logic [sel_w(N)-1:0]   ptr,
    output logic                  found,
    output logic [sel_w(N)-1:0]   idx,
    output logic [N-1:0]          onehot
);

    // Walk offsets ptr+1, ptr+2, ... ptr+N and take the first set request.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
                    found     = 1'b1;
                    idx       = sel_w(N)'(i);
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_read_port_arbiter.sv
// Round-robin owner of the shared register-file read port, with hold limit
// and registered read-response capture.
module rf_read_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    output logic [ADDR_W-1:0]                rf_addr,
    input  logic [DATA_W-1:0]                rf_rdata,
    output logic [sel_w(NUM_REQ)-1:0]        sel,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]                rsp_data,
    output logic                             busy
);

    localparam int SEL_W  = sel_w(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [SEL_W-1:0]  PTR_INIT  = SEL_W'(NUM_REQ - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]  pick_vec;
    logic [SEL_W-1:0]    pick_ptr;
    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic                owner_req;
    logic [NUM_REQ-1:0]  xfer_vec;

    // Candidates exclude the current owner; in OWN the search starts after the owner.
    assign pick_vec = req & ~gnt_q;
    assign pick_ptr = (state_q == OWN) ? sel_q : rr_ptr_q;

    rr_priority_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req    (pick_vec),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // State, grant, pointer and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            hold_cnt_q  <= '0;
            rr_ptr_q    <= PTR_INIT;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            hold_cnt_q  <= hold_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next owner: keep, rotate on hold expiry, hand over on drop, or go idle.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        owner_req  = |(req & gnt_q);
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = OWN;
                    gnt_d      = pick_onehot;
                    sel_d      = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            OWN: begin
                if (owner_req && ((hold_cnt_q < HOLD_LAST) || !pick_found)) begin
                    if (hold_cnt_q < HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else begin
                    rr_ptr_d   = sel_q;
                    hold_cnt_d = '0;
                    if (pick_found) begin
                        gnt_d = pick_onehot;
                        sel_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        sel_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address mux toward the register file and response capture on a transfer.
    always_comb begin
        xfer_vec = req & gnt_q;
        rf_addr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                rf_addr = req_addr[i];
            end
        end
        rsp_valid_d = xfer_vec;
        rsp_data_d  = rsp_data_q;
        if (|xfer_vec) begin
            rsp_data_d = rf_rdata;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q == OWN);

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Directed bench for rf_read_port_arbiter: per-cycle grant/address checks plus
// a response scoreboard drained by an independent monitor.
module tb_rf_read_port_arbiter;
    import rf_arb_pkg::*;

    localparam int SEL_W = sel_w(4);
    localparam logic [3:0][4:0] ADDRS = {5'd12, 5'd7, 5'd9, 5'd4};

    typedef struct packed {
        logic [3:0]  vld;
        logic [31:0] data;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req, reqRr;
    logic [3:0][4:0]  reqAddr;
    logic [4:0]       rfAddr, rfAddrRr;
    logic [31:0]      rfRdata, rfRdataRr;
    logic [SEL_W-1:0] sel, selRr;
    logic [3:0]       gnt, gntRr, rspValid, rspValidRr;
    logic [31:0]      rspData, rspDataRr;
    logic             busy, busyRr;
    logic [31:0]      mem [32];
    rsp_t             expQ[$];
    int               testsRun = 0;
    int               testsFailed = 0;

    always #5 clk = ~clk;

    assign rfRdata   = mem[rfAddr];
    assign rfRdataRr = mem[rfAddrRr];

    rf_read_port_arbiter #(
        .NUM_REQ(4), .ADDR_W(5), .DATA_W(32), .MAX_HOLD(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(reqAddr),
        .rf_addr(rfAddr), .rf_rdata(rfRdata), .sel(sel), .gnt(gnt),
        .rsp_valid(rspValid), .rsp_data(rspData), .busy(busy)
    );

    rf_read_port_arbiter #(
        .NUM_REQ(4), .ADDR_W(5), .DATA_W(32), .MAX_HOLD(1)
    ) dutRr (
        .clk(clk), .rst(rst), .req(reqRr), .req_addr(reqAddr),
        .rf_addr(rfAddrRr), .rf_rdata(rfRdataRr), .sel(selRr), .gnt(gntRr),
        .rsp_valid(rspValidRr), .rsp_data(rspDataRr), .busy(busyRr)
    );

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0][4:0] addrs);
        @(negedge clk);
        req     = r;
        reqAddr = addrs;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expGnt, input logic [4:0] expAddr);
        logic [SEL_W-1:0] expSel;
        logic [4:0]       expRf;
        expSel = '0;
        for (int i = 0; i < 4; i++) begin
            if (expGnt[i]) expSel = SEL_W'(i);
        end
        expRf = (expGnt != 4'b0) ? expAddr : 5'd0;
        compareValue({name, "_gnt"},     32'(gnt),    32'(expGnt));
        compareValue({name, "_sel"},     32'(sel),    32'(expSel));
        compareValue({name, "_busy"},    32'(busy),   32'(expGnt != 4'b0));
        compareValue({name, "_rf_addr"}, 32'(rfAddr), 32'(expRf));
    endtask

    task automatic step(input string name, input logic [3:0] r, input logic [3:0][4:0] addrs,
                        input logic [3:0] expGnt, input logic [4:0] expAddr, input bit pushRsp);
        rsp_t e;
        applyStimulus(r, addrs);
        checkOutput(name, expGnt, expAddr);
        if (pushRsp) begin
            e.vld  = expGnt;
            e.data = mem[expAddr];
            expQ.push_back(e);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst   = 1'b1;
        req   = '0;
        reqRr = '0;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expected entry.
    always begin
        rsp_t e;
        @(posedge clk);
        #2;
        if (rspValid !== 4'b0) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL rsp_unexpected: got valid=%b data=%h expected no response", rspValid, rspData);
            end else begin
                e = expQ.pop_front();
                if ({rspValid, rspData} !== {e.vld, e.data}) begin
                    testsFailed++;
                    $display("[TB] FAIL rsp: got valid=%b data=%h expected valid=%b data=%h",
                             rspValid, rspData, e.vld, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0]      rrSeq [5];
        logic [3:0]      g;
        logic [3:0][4:0] a;
        rrSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
        mem[7] = 32'hDEAD_BEEF;
        rst = 1'b1; req = '0; reqRr = '0; reqAddr = ADDRS;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset", 4'b0, 5'd0);
        compareValue("reset_rsp_valid", 32'(rspValid), 32'd0);
        compareValue("reset_rsp_data", rspData, 32'd0);
        compareValue("reset_rr_gnt", 32'(gntRr), 32'd0);
        rst = 1'b0;

        // Single read with bubble
        step("t2_c0", 4'b0100, ADDRS, 4'b0000, 5'd0, 0);
        step("t2_c1", 4'b0100, ADDRS, 4'b0100, 5'd7, 1);
        step("t2_c2", 4'b0100, ADDRS, 4'b0100, 5'd7, 1);
        step("t2_c3_bubble", 4'b0000, ADDRS, 4'b0100, 5'd7, 0);
        step("t2_c4_idle", 4'b0000, ADDRS, 4'b0000, 5'd0, 0);
        compareValue("t2_rsp_hold", rspData, 32'hDEAD_BEEF);
        compareValue("t2_rsp_quiet", 32'(rspValid), 32'd0);

        // Asynchronous reset in the middle of a transfer
        doReset();
        step("t1_c0", 4'b1111, ADDRS, 4'b0000, 5'd0, 0);
        step("t1_c1", 4'b1111, ADDRS, 4'b0001, 5'd4, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        compareValue("t1_rst_gnt", 32'(gnt), 32'd0);
        compareValue("t1_rst_rsp_valid", 32'(rspValid), 32'd0);
        compareValue("t1_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("t1_first", 4'b1111, ADDRS, 4'b0001, 5'd4, 1);
        step("t1_drop", 4'b0000, ADDRS, 4'b0001, 5'd4, 0);
        step("t1_idle", 4'b0000, ADDRS, 4'b0000, 5'd0, 0);

        // Round robin with MAX_HOLD=1
        doReset();
        @(negedge clk);
        reqRr = 4'b1111;
        #1;
        compareValue("t3_c0_gnt", 32'(gntRr), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            compareValue($sformatf("t3_c%0d_gnt", k + 1), 32'(gntRr), 32'(rrSeq[k]));
        end
        compareValue("t3_sel", 32'(selRr), 32'd0);
        reqRr = 4'b0000;

        // Hold limit with two requesters
        doReset();
        step("t4_c0", 4'b0011, ADDRS, 4'b0000, 5'd0, 0);
        for (int c = 1; c <= 12; c++) begin
            g = (((c - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
            step($sformatf("t4_c%0d", c), 4'b0011, ADDRS, g, (g == 4'b0001) ? 5'd4 : 5'd9, 1);
        end
        step("t4_bubble", 4'b0000, ADDRS, 4'b0010, 5'd9, 0);
        step("t4_idle", 4'b0000, ADDRS, 4'b0000, 5'd0, 0);

        // Single requester never rotates away
        doReset();
        step("t4b_c0", 4'b0001, ADDRS, 4'b0000, 5'd0, 0);
        for (int c = 1; c <= 10; c++) begin
            step($sformatf("t4b_c%0d", c), 4'b0001, ADDRS, 4'b0001, 5'd4, 1);
        end
        step("t4b_bubble", 4'b0000, ADDRS, 4'b0001, 5'd4, 0);
        step("t4b_idle", 4'b0000, ADDRS, 4'b0000, 5'd0, 0);

        // Owner drops while another requester waits
        doReset();
        step("t5_c0", 4'b0010, ADDRS, 4'b0000, 5'd0, 0);
        step("t5_c1", 4'b1010, ADDRS, 4'b0010, 5'd9, 1);
        step("t5_c2_drop", 4'b1000, ADDRS, 4'b0010, 5'd9, 0);
        step("t5_c3", 4'b1000, ADDRS, 4'b1000, 5'd12, 1);
        step("t5_c4_bubble", 4'b0000, ADDRS, 4'b1000, 5'd12, 0);
        step("t5_c5_idle", 4'b0000, ADDRS, 4'b0000, 5'd0, 0);

        // Address changes between back-to-back transfers
        doReset();
        a = {5'd12, 5'd7, 5'd9, 5'd1};
        step("t6_c0", 4'b0001, a, 4'b0000, 5'd0, 0);
        step("t6_c1", 4'b0001, a, 4'b0001, 5'd1, 1);
        a[0] = 5'd2;
        step("t6_c2", 4'b0001, a, 4'b0001, 5'd2, 1);
        a[0] = 5'd3;
        step("t6_c3", 4'b0001, a, 4'b0001, 5'd3, 1);
        step("t6_c4_bubble", 4'b0000, a, 4'b0001, 5'd3, 0);
        step("t6_c5_idle", 4'b0000, a, 4'b0000, 5'd0, 0);

        repeat (3) @(negedge clk);
        compareValue("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
